// File: rtl/hog_sqrt_sched.sv
// Time-shares N_SQRT pipelined sqrt lanes across one 36-element HOG bundle and reassembles results.
// Optional ZERO_SKIP_EN: all-zero groups are not issued and their results are written as 0 directly.
module hog_sqrt_sched #(
    parameter int N_ELEM   = 36,
    parameter int N_SQRT   = 4,
    parameter int IN_W     = 20,
    parameter int OUT_W    = 12,
    parameter int SQRT_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_ELEM*IN_W-1:0]  in_data,
    output logic [N_SQRT*IN_W-1:0]  sq_num,
    input  logic [N_SQRT*OUT_W-1:0] sq_res,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_ELEM*OUT_W-1:0] out_data,
    output logic                    busy,
    output logic [1:0]              dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid/data are held by the source until then, and ready never depends on valid.
    localparam int G  = (N_ELEM + N_SQRT - 1) / N_SQRT;
    localparam int GW = (G > 1) ? $clog2(G) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_e;

    state_e              state_q, state_d;
    logic [GW-1:0]       grp_q, grp_d;
    logic [IN_W-1:0]     ibuf_q [N_ELEM];
    logic [OUT_W-1:0]    obuf_q [N_ELEM];
    logic [SQRT_LAT-1:0] tag_live_q, tag_vld_q;
    logic [GW-1:0]       tag_grp_q [SQRT_LAT];

    logic [IN_W-1:0]         lane_num [N_SQRT];
    logic [OUT_W-1:0]        lane_res [N_SQRT];
    logic [N_SQRT*IN_W-1:0]  issue_flat;
    logic                    issuing, issue_vld, accept, drain_done;

    assign dbg_state = state_q;
    assign issuing   = (state_q == S_ISSUE);
    assign accept    = (state_q == S_IDLE) && in_valid;

    always_comb begin
        state_d   = state_q;
        grp_d     = grp_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_d = S_ISSUE;
                    grp_d   = '0;
                end
            end
            S_ISSUE: begin
                if (grp_q == GW'(G - 1)) state_d = S_DRAIN;
                else                     grp_d   = grp_q + 1'b1;
            end
            S_DRAIN: begin
                if (drain_done) state_d = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grp_q   <= '0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
        end
    end

    // Lane l of the current group carries element grp*N_SQRT+l; indices past the bundle stay 0.
    always_comb begin
        for (int l = 0; l < N_SQRT; l++) lane_num[l] = '0;
        for (int e = 0; e < N_ELEM; e++) begin
            if (grp_q == GW'(e / N_SQRT)) lane_num[e % N_SQRT] = ibuf_q[e];
        end
        issue_flat = '0;
        for (int l = 0; l < N_SQRT; l++) issue_flat[IN_W*(N_SQRT-l)-1 -: IN_W] = lane_num[l];
        for (int l = 0; l < N_SQRT; l++) lane_res[l] = sq_res[OUT_W*(N_SQRT-l)-1 -: OUT_W];
    end

`ifdef ZERO_SKIP_EN
    logic [N_SQRT*IN_W-1:0] sq_hold_q;

    assign issue_vld = |issue_flat;

    always_ff @(posedge clk) begin
        if (!rst_n) sq_hold_q <= '0;
        else        sq_hold_q <= sq_num;
    end

    always_comb begin
        sq_num = '0;
        if (issuing) sq_num = issue_vld ? issue_flat : sq_hold_q;
    end
`else
    assign issue_vld = 1'b1;

    always_comb begin
        sq_num = '0;
        if (issuing) sq_num = issue_flat;
    end
`endif

    // The last stage is the tag whose result is on sq_res this cycle, so only earlier stages
    // need to be empty before moving to OUT on this edge.
    always_comb begin
        drain_done = 1'b1;
        for (int i = 0; i < SQRT_LAT - 1; i++) begin
            if (tag_live_q[i]) drain_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_live_q <= '0;
            tag_vld_q  <= '0;
            for (int i = 0; i < SQRT_LAT; i++) tag_grp_q[i] <= '0;
            for (int e = 0; e < N_ELEM; e++) begin
                ibuf_q[e] <= '0;
                obuf_q[e] <= '0;
            end
        end else begin
            tag_live_q[0] <= issuing;
            tag_vld_q[0]  <= issuing && issue_vld;
            tag_grp_q[0]  <= grp_q;
            for (int i = SQRT_LAT - 1; i > 0; i--) begin
                tag_live_q[i] <= tag_live_q[i-1];
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_grp_q[i]  <= tag_grp_q[i-1];
            end
            if (accept) begin
                for (int e = 0; e < N_ELEM; e++) ibuf_q[e] <= in_data[IN_W*(N_ELEM-e)-1 -: IN_W];
            end
            for (int e = 0; e < N_ELEM; e++) begin
                if (tag_vld_q[SQRT_LAT-1] && (tag_grp_q[SQRT_LAT-1] == GW'(e / N_SQRT)))
                    obuf_q[e] <= lane_res[e % N_SQRT];
`ifdef ZERO_SKIP_EN
                else if (issuing && !issue_vld && (grp_q == GW'(e / N_SQRT)))
                    obuf_q[e] <= '0;
`endif
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int e = 0; e < N_ELEM; e++) out_data[OUT_W*(N_ELEM-e)-1 -: OUT_W] = obuf_q[e];
    end

endmodule

// File: tb/tb_hog_sqrt_sched.sv
// Self-checking bench for hog_sqrt_sched: sqrt-unit stubs, bundle-level reference model, scenario tasks.
module tb_hog_sqrt_sched;
    localparam int N_ELEM = 36, N_SQRT = 4, IN_W = 20, OUT_W = 12, SQRT_LAT = 2;
    localparam int G      = (N_ELEM + N_SQRT - 1) / N_SQRT;
    localparam int LAT    = G + SQRT_LAT + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                    in_valid = 1'b0, out_ready = 1'b1, x_valid = 1'b0;
    logic                    in_ready, out_valid, busy;
    logic [1:0]              dbg_state;
    logic [N_ELEM*IN_W-1:0]  in_data = '0;
    logic [N_SQRT*IN_W-1:0]  sq_num;
    logic [N_SQRT*OUT_W-1:0] sq_res;
    logic [N_ELEM*OUT_W-1:0] out_data;

    int cyc = 0, x_acc = 0, total = 0, bad = 0;
    logic [IN_W-1:0]  stim [N_ELEM];
    logic [OUT_W-1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [OUT_W-1:0] isqrt(input logic [IN_W-1:0] x);
        int r = 0;
        int t;
        for (int b = OUT_W - 1; b >= 0; b--) begin
            t = r | (1 << b);
            if (t * t <= int'(x)) r = t;
        end
        return OUT_W'(r);
    endfunction

    function automatic logic [N_ELEM*IN_W-1:0] pack_stim();
        logic [N_ELEM*IN_W-1:0] v = '0;
        for (int i = 0; i < N_ELEM; i++) v[IN_W*(N_ELEM-i)-1 -: IN_W] = stim[i];
        return v;
    endfunction

    hog_sqrt_sched #(.N_ELEM(N_ELEM), .N_SQRT(N_SQRT), .IN_W(IN_W), .OUT_W(OUT_W),
                     .SQRT_LAT(SQRT_LAT)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .sq_num(sq_num), .sq_res(sq_res), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .dbg_state(dbg_state)
    );

    // Pipelined sqrt unit stub: operand in cycle c, result on sq_res in cycle c+SQRT_LAT.
    logic [OUT_W-1:0] m_pipe [SQRT_LAT][N_SQRT];
    always @(posedge clk) begin
        for (int l = 0; l < N_SQRT; l++) m_pipe[0][l] <= isqrt(sq_num[IN_W*(N_SQRT-l)-1 -: IN_W]);
        for (int s = 1; s < SQRT_LAT; s++)
            for (int l = 0; l < N_SQRT; l++) m_pipe[s][l] <= m_pipe[s-1][l];
    end
    always_comb begin
        sq_res = '0;
        for (int l = 0; l < N_SQRT; l++) sq_res[OUT_W*(N_SQRT-l)-1 -: OUT_W] = m_pipe[SQRT_LAT-1][l];
    end

    // Alternate configurations: 6 lanes / latency 1, and 5 lanes / latency 4 (partial last group).
    for (genvar k = 0; k < 2; k++) begin : g_x
        localparam int NS = (k == 0) ? 6 : 5;
        localparam int LT = (k == 0) ? 1 : 4;
        localparam int GK = (N_ELEM + NS - 1) / NS;
        logic                    rdy, ov, bz;
        logic [1:0]              ds;
        logic [NS*IN_W-1:0]      num, last_num;
        logic [NS*OUT_W-1:0]     res;
        logic [N_ELEM*OUT_W-1:0] od, cap;
        logic [OUT_W-1:0]        pipe [LT][NS];
        int                      first_cyc = -1;

        hog_sqrt_sched #(.N_ELEM(N_ELEM), .N_SQRT(NS), .IN_W(IN_W), .OUT_W(OUT_W),
                         .SQRT_LAT(LT)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(rdy), .in_data(in_data),
            .sq_num(num), .sq_res(res), .out_valid(ov), .out_ready(1'b1),
            .out_data(od), .busy(bz), .dbg_state(ds)
        );

        always @(posedge clk) begin
            for (int l = 0; l < NS; l++) pipe[0][l] <= isqrt(num[IN_W*(NS-l)-1 -: IN_W]);
            for (int s = 1; s < LT; s++)
                for (int l = 0; l < NS; l++) pipe[s][l] <= pipe[s-1][l];
        end
        always_comb begin
            res = '0;
            for (int l = 0; l < NS; l++) res[OUT_W*(NS-l)-1 -: OUT_W] = pipe[LT-1][l];
        end
        always @(negedge clk) begin
            if (cyc - x_acc == GK) last_num = num;
            if (ov && first_cyc < 0) begin
                first_cyc = cyc - x_acc;
                cap       = od;
            end
        end
    end

    // Driver: present stim as one bundle, record its expected results, return in cycle 1.
    task automatic send();
        int n = 0;
        in_data = pack_stim();
        for (int i = 0; i < N_ELEM; i++) exp_q.push_back(isqrt(stim[i]));
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int start, output int lat);
        lat = start;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic pop_exp(output logic [N_ELEM*OUT_W-1:0] v);
        v = '0;
        for (int i = 0; i < N_ELEM; i++)
            if (exp_q.size() > 0) v[OUT_W*(N_ELEM-i)-1 -: OUT_W] = exp_q.pop_front();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (sq_num !== '0) begin bad++; $display("FAIL reset_sq_num got=%h exp=0", sq_num); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    endtask

    task automatic test_squares();
        logic [N_SQRT*IN_W-1:0]  exp_sq;
        logic [N_ELEM*OUT_W-1:0] exp_v;
        int idx, wrong;
        for (int i = 0; i < N_ELEM; i++) stim[i] = IN_W'(i * i);
        out_ready = 1'b1;
        send();
        for (int c = 1; c <= LAT; c++) begin
            exp_sq = '0;
            if (c <= G) begin
                for (int l = 0; l < N_SQRT; l++) begin
                    idx = (c - 1) * N_SQRT + l;
                    if (idx < N_ELEM) exp_sq[IN_W*(N_SQRT-l)-1 -: IN_W] = stim[idx];
                end
            end
            total++; if (sq_num !== exp_sq) begin bad++; $display("FAIL squares_sq_num c=%0d got=%h exp=%h", c, sq_num, exp_sq); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL squares_busy c=%0d got=%b exp=1", c, busy); end
            total++; if (out_valid !== (c == LAT)) begin bad++; $display("FAIL squares_out_valid c=%0d got=%b exp=%b", c, out_valid, c == LAT); end
            if (c == LAT) begin
                pop_exp(exp_v);
                total++; if (out_data !== exp_v) begin bad++; $display("FAIL squares_data got=%h exp=%h", out_data, exp_v); end
                wrong = 0;
                for (int i = 0; i < N_ELEM; i++)
                    if (out_data[OUT_W*(N_ELEM-i)-1 -: OUT_W] !== OUT_W'(i)) wrong++;
                total++; if (wrong != 0) begin bad++; $display("FAIL squares_elem_eq_index got=%0d wrong elems exp=0", wrong); end
            end
            @(negedge clk);
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL squares_busy_after got=%b exp=0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL squares_in_ready_after got=%b exp=1", in_ready); end
    endtask

    task automatic test_backpressure();
        logic [N_ELEM*OUT_W-1:0] exp_a, exp_b;
        int lat;
        for (int i = 0; i < N_ELEM; i++) stim[i] = IN_W'($urandom_range(0, (1 << IN_W) - 1));
        out_ready = 1'b0;
        send();
        wait_out(1, lat);
        total++; if (lat != LAT) begin bad++; $display("FAIL bp_latency got=%0d exp=%0d", lat, LAT); end
        pop_exp(exp_a);
        for (int i = 0; i < N_ELEM; i++) stim[i] = IN_W'($urandom_range(0, (1 << IN_W) - 1));
        in_data = pack_stim();
        for (int j = 0; j < 10; j++) begin
            in_valid = (j % 2 == 0);
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_a) begin
                bad++;
                $display("FAIL bp_hold j=%0d got ov=%b rdy=%b data=%h exp ov=1 rdy=0 data=%h", j, out_valid, in_ready, out_data, exp_a);
            end
            @(negedge clk);
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_after_handshake got ov=%b rdy=%b exp ov=0 rdy=1", out_valid, in_ready); end
        for (int i = 0; i < N_ELEM; i++) exp_q.push_back(isqrt(stim[i]));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(1, lat);
        total++; if (lat != LAT) begin bad++; $display("FAIL bp_second_latency got=%0d exp=%0d", lat, LAT); end
        pop_exp(exp_b);
        total++; if (out_data !== exp_b) begin bad++; $display("FAIL bp_second_data got=%h exp=%h", out_data, exp_b); end
        @(negedge clk);
    endtask

    task automatic test_all_ones();
        logic [N_ELEM*OUT_W-1:0] exp_v;
        logic [N_SQRT*IN_W-1:0]  exp_sq;
        int lat;
        for (int i = 0; i < N_ELEM; i++) stim[i] = '1;
        out_ready = 1'b1;
        send();
        repeat (G - 1) @(negedge clk);
        exp_sq = '0;
        for (int l = 0; l < N_SQRT; l++)
            if ((G - 1) * N_SQRT + l < N_ELEM) exp_sq[IN_W*(N_SQRT-l)-1 -: IN_W] = '1;
        total++; if (sq_num !== exp_sq) begin bad++; $display("FAIL ones_last_group got=%h exp=%h", sq_num, exp_sq); end
        wait_out(G, lat);
        total++; if (lat != LAT) begin bad++; $display("FAIL ones_latency got=%0d exp=%0d", lat, LAT); end
        pop_exp(exp_v);
        total++; if (out_data !== exp_v) begin bad++; $display("FAIL ones_data got=%h exp=%h", out_data, exp_v); end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        logic [N_ELEM*OUT_W-1:0] exp_v;
        int lat, wrong;
        for (int i = 0; i < N_ELEM; i++) stim[i] = IN_W'($urandom_range(1, (1 << IN_W) - 1));
        out_ready = 1'b1;
        send();
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_idle got rdy=%b ov=%b busy=%b exp rdy=1 ov=0 busy=0", in_ready, out_valid, busy);
        end
        for (int i = 0; i < N_ELEM; i++) stim[i] = IN_W'(4);
        send();
        wait_out(1, lat);
        total++; if (lat != LAT) begin bad++; $display("FAIL midreset_latency got=%0d exp=%0d", lat, LAT); end
        pop_exp(exp_v);
        total++; if (out_data !== exp_v) begin bad++; $display("FAIL midreset_data got=%h exp=%h", out_data, exp_v); end
        wrong = 0;
        for (int i = 0; i < N_ELEM; i++)
            if (out_data[OUT_W*(N_ELEM-i)-1 -: OUT_W] !== OUT_W'(2)) wrong++;
        total++; if (wrong != 0) begin bad++; $display("FAIL midreset_twos got=%0d wrong elems exp=0", wrong); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [N_ELEM*OUT_W-1:0] exp_v;
        int lat;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < N_ELEM; i++)
                stim[i] = ($urandom_range(0, 3) == 0) ? '0 : IN_W'($urandom_range(0, (1 << IN_W) - 1));
            out_ready = 1'b0;
            send();
            wait_out(1, lat);
            total++; if (lat != LAT) begin bad++; $display("FAIL b2b_latency b=%0d got=%0d exp=%0d", b, lat, LAT); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pop_exp(exp_v);
            total++; if (out_valid !== 1'b1 || out_data !== exp_v) begin bad++; $display("FAIL b2b_data b=%0d ov=%b got=%h exp=%h", b, out_valid, out_data, exp_v); end
            out_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_zero_group();
        logic [N_SQRT*IN_W-1:0]  prev, exp_sq;
        logic [N_ELEM*OUT_W-1:0] exp_v;
        int wrong;
        prev = '0;
        for (int i = 0; i < N_ELEM; i++)
            stim[i] = (i >= 8 && i <= 11) ? '0 : IN_W'($urandom_range(1, (1 << IN_W) - 1));
        out_ready = 1'b1;
        send();
        for (int c = 1; c <= LAT; c++) begin
            if (c == 2) prev = sq_num;
            if (c == 3) begin
`ifdef ZERO_SKIP_EN
                exp_sq = prev;
`else
                exp_sq = '0;
`endif
                total++; if (sq_num !== exp_sq) begin bad++; $display("FAIL zero_group_sq_num got=%h exp=%h", sq_num, exp_sq); end
            end
            if (c == LAT) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL zero_group_latency got=%b exp=1", out_valid); end
                pop_exp(exp_v);
                total++; if (out_data !== exp_v) begin bad++; $display("FAIL zero_group_data got=%h exp=%h", out_data, exp_v); end
                wrong = 0;
                for (int i = 8; i <= 11; i++)
                    if (out_data[OUT_W*(N_ELEM-i)-1 -: OUT_W] !== '0) wrong++;
                total++; if (wrong != 0) begin bad++; $display("FAIL zero_group_outs got=%0d nonzero exp=0", wrong); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_configs();
        logic [N_ELEM*OUT_W-1:0] exp_v;
        logic [6*IN_W-1:0]       exp_n0;
        logic [5*IN_W-1:0]       exp_n1;
        int g0, g1;
        g0 = (N_ELEM + 5) / 6;
        g1 = (N_ELEM + 4) / 5;
        for (int i = 0; i < N_ELEM; i++) stim[i] = IN_W'($urandom_range(1, (1 << IN_W) - 1));
        exp_v = '0;
        for (int i = 0; i < N_ELEM; i++) exp_v[OUT_W*(N_ELEM-i)-1 -: OUT_W] = isqrt(stim[i]);
        exp_n0 = '0;
        exp_n1 = '0;
        for (int l = 0; l < 6; l++)
            if ((g0 - 1) * 6 + l < N_ELEM) exp_n0[IN_W*(6-l)-1 -: IN_W] = stim[(g0 - 1) * 6 + l];
        for (int l = 0; l < 5; l++)
            if ((g1 - 1) * 5 + l < N_ELEM) exp_n1[IN_W*(5-l)-1 -: IN_W] = stim[(g1 - 1) * 5 + l];
        in_data = pack_stim();
        x_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        x_valid = 1'b0;
        x_acc   = cyc - 1;
        repeat (20) @(negedge clk);
        total++; if (g_x[0].first_cyc != g0 + 1 + 1) begin bad++; $display("FAIL cfg6_lat1_latency got=%0d exp=%0d", g_x[0].first_cyc, g0 + 2); end
        total++; if (g_x[0].cap !== exp_v) begin bad++; $display("FAIL cfg6_lat1_data got=%h exp=%h", g_x[0].cap, exp_v); end
        total++; if (g_x[0].last_num !== exp_n0) begin bad++; $display("FAIL cfg6_last_group got=%h exp=%h", g_x[0].last_num, exp_n0); end
        total++; if (g_x[1].first_cyc != g1 + 4 + 1) begin bad++; $display("FAIL cfg5_lat4_latency got=%0d exp=%0d", g_x[1].first_cyc, g1 + 5); end
        total++; if (g_x[1].cap !== exp_v) begin bad++; $display("FAIL cfg5_lat4_data got=%h exp=%h", g_x[1].cap, exp_v); end
        total++; if (g_x[1].last_num !== exp_n1) begin bad++; $display("FAIL cfg5_last_group got=%h exp=%h", g_x[1].last_num, exp_n1); end
    endtask

    initial begin
        test_reset();
        test_squares();
        test_backpressure();
        test_all_ones();
        test_mid_reset();
        test_back_to_back();
        test_zero_group();
        test_configs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
